mp_in_packer: RTL and testbench

- Receive-side message packer for the SHA-256 UART datapath; it is the counterpart of the digest-serialising output block.
- Collects 64 UART RX bytes, one 512-bit message block, in big-endian order into an internal buffer.
- Then streams the block to the SHA-256 core as 16 32-bit words over a valid/ready handshake.
- Sits between the UART receiver and the core's message-schedule input.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/mp_in_packer_if.sv | 31 +++
 rtl/mp_in_byte_buf.sv | 37 +++
 rtl/mp_in_packer.sv | 147 ++++++++++++++
 tb/tb_mp_in_packer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 datapath constants and the message-packer FSM state type.
package sha256_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_BLOCK_BITS  = 512;
  localparam int SHA_BLOCK_BYTES = 64;
  localparam int SHA_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2,
    ST_CLEANUP = 2'd3
  } mp_state_e;

endpackage

// File: rtl/mp_in_packer_if.sv
// UART-RX byte input and SHA-256 core word-stream signals of the message packer.
interface mp_in_packer_if #(
  parameter int DATA_WIDTH = 32
);

  logic [7:0]            RX_byte_in;
  logic                  RX_DV_in;
  logic                  core_ready_in;
  logic [DATA_WIDTH-1:0] MP_word_out;
  logic                  MP_valid_out;
  logic                  MP_last_out;
  logic [3:0]            MP_word_idx_out;
  logic                  MP_busy_out;
  logic                  MP_overrun_out;
  logic                  MP_timeout_out;

  // The packer's own view.
  modport slave (
    input  RX_byte_in, RX_DV_in, core_ready_in,
    output MP_word_out, MP_valid_out, MP_last_out, MP_word_idx_out,
           MP_busy_out, MP_overrun_out, MP_timeout_out
  );

  // The surroundings: UART receiver plus SHA-256 core.
  modport master (
    output RX_byte_in, RX_DV_in, core_ready_in,
    input  MP_word_out, MP_valid_out, MP_last_out, MP_word_idx_out,
           MP_busy_out, MP_overrun_out, MP_timeout_out
  );

endinterface

// File: rtl/mp_in_byte_buf.sv
// 512-bit message block store: indexed byte writes (byte 0 = MSB) and big-endian word read mux.
module mp_in_byte_buf
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [5:0]            wr_idx_i,
  input  logic [7:0]            wr_byte_i,
  input  logic [3:0]            rd_idx_i,
  output logic [SHA_WORD_W-1:0] rd_word_o
);

  logic [SHA_BLOCK_BITS-1:0] blk_q;
  logic [8:0]                wr_lsb;
  logic [8:0]                rd_lsb;

  // Byte n occupies [511-8n -: 8], whose LSB is 8*(63-n) = {~n, 3'b0}; words likewise.
  assign wr_lsb = {~wr_idx_i, 3'b000};
  assign rd_lsb = {~rd_idx_i, 5'b00000};

  // NOTE: the block store is reset like any other register because a freshly reset
  // packer must present an all-zero buffer; drop the reset only if that guarantee goes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
    end else if (clr_i) begin
      blk_q <= '0;
    end else if (wr_en_i) begin
      blk_q[wr_lsb +: 8] <= wr_byte_i;
    end
  end

  assign rd_word_o = blk_q[rd_lsb +: SHA_WORD_W];

endmodule

// File: rtl/mp_in_packer.sv
// Receive-side message packer: 64 UART bytes -> 16 big-endian 32-bit words for the SHA-256 core.
// Optional inter-byte idle timeout is compiled in when MP_IN_TIMEOUT_EN is defined.
module mp_in_packer
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH      = SHA_WORD_W,
  parameter int WORDS_PER_BLOCK = SHA_BLOCK_WORDS,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  mp_in_packer_if.slave mp
);

  localparam logic [6:0] LAST_BYTE   = 7'(4 * WORDS_PER_BLOCK - 1);
  localparam logic [3:0] LAST_WORD   = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] PENULT_WORD = 4'(WORDS_PER_BLOCK - 2);

  // The datapath is hard-wired to SHA-256 geometry; refuse any other build.
  if (DATA_WIDTH != SHA_WORD_W || WORDS_PER_BLOCK != SHA_BLOCK_WORDS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mp_in_packer: unsupported parameter set");
  end

  mp_state_e             state_q;
  logic [6:0]            cnt_q;
  logic [3:0]            idx_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  timeout_q;
  logic                  rx_take;
  logic                  to_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  assign rx_take = mp.RX_DV_in && (state_q == ST_IDLE || state_q == ST_COLLECT);

`ifdef MP_IN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  // A strobe in the expiry cycle wins, so the byte is kept and the block survives.
  assign to_fire = (state_q == ST_COLLECT) && !mp.RX_DV_in && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_COLLECT && !mp.RX_DV_in && !to_fire) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  mp_in_byte_buf u_byte_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (to_fire),
    .wr_en_i   (rx_take),
    .wr_idx_i  (cnt_q[5:0]),
    .wr_byte_i (mp.RX_byte_in),
    .rd_idx_i  (idx_q),
    .rd_word_o (rd_word)
  );

  // NOTE: every register here is updated with <= so all of them see the same pre-edge
  // values; a blocking update would leak a new state into later lines of this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      case (state_q)
        ST_IDLE: begin
          if (mp.RX_DV_in) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= 7'd1;
            busy_q    <= 1'b1;
            overrun_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (mp.RX_DV_in) begin
            if (cnt_q == LAST_BYTE) begin
              state_q <= ST_SEND;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              last_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 7'd1;
            end
          end else if (to_fire) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (mp.RX_DV_in) begin
            overrun_q <= 1'b1;
          end
          if (valid_q && mp.core_ready_in) begin
            if (idx_q == LAST_WORD) begin
              state_q <= ST_CLEANUP;
              idx_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + 4'd1;
              last_q <= (idx_q == PENULT_WORD);
            end
          end
        end
        ST_CLEANUP: begin
          if (mp.RX_DV_in) begin
            overrun_q <= 1'b1;
          end
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mp.MP_word_out     = valid_q ? rd_word : '0;
  assign mp.MP_valid_out    = valid_q;
  assign mp.MP_last_out     = last_q;
  assign mp.MP_word_idx_out = idx_q;
  assign mp.MP_busy_out     = busy_q;
  assign mp.MP_overrun_out  = overrun_q;
  assign mp.MP_timeout_out  = timeout_q;

endmodule

// File: tb/tb_mp_in_packer.sv
// Self-checking bench for mp_in_packer: byte-level driver, queue-based block model, per-cycle output monitor.
module tb_mp_in_packer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mp_in_packer_if #(.DATA_WIDTH(32)) bus ();

  mp_in_packer #(
    .DATA_WIDTH      (32),
    .WORDS_PER_BLOCK (16),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mp    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: accepted bytes of the block being gathered, and the words still owed.
  byte unsigned rx_q[$];
  logic [31:0]  exp_q[$];
  byte unsigned blk[64];
  bit           blk_busy = 1'b0;
  bit           drain    = 1'b0;
  bit           exp_ovr  = 1'b0;
  bit           rand_ready = 1'b0;
  int           exp_idx  = 0;
  int           n_xfer   = 0;
  int           n_pulse  = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.MP_timeout_out === 1'b1) n_pulse++;
      if (drain) begin
        drain    = 1'b0;
        blk_busy = 1'b0;
      end
      if (exp_q.size() == 0) check("valid_without_block", bus.MP_valid_out, 0);
      if (bus.MP_valid_out === 1'b1 && exp_q.size() != 0 && bus.core_ready_in === 1'b1) begin
        check("word", bus.MP_word_out, exp_q.pop_front());
        check("idx", bus.MP_word_idx_out, exp_idx);
        check("last", bus.MP_last_out, exp_idx == 15);
        n_xfer++;
        if (exp_idx == 15) begin
          exp_idx = 0;
          drain   = 1'b1;
        end else begin
          exp_idx++;
        end
      end
      if (bus.MP_valid_out !== 1'b1) begin
        check("word_when_invalid", bus.MP_word_out, 0);
        check("last_when_invalid", bus.MP_last_out, 0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.core_ready_in = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input byte unsigned b);
    bit done = 1'b0;
    bus.RX_byte_in = b;
    bus.RX_DV_in   = 1'b1;
    if (blk_busy) begin
      exp_ovr = 1'b1;
    end else begin
      if (rx_q.size() == 0) exp_ovr = 1'b0;
      rx_q.push_back(b);
      if (rx_q.size() == 64) begin
        for (int w = 0; w < 16; w++)
          exp_q.push_back({rx_q[4*w], rx_q[4*w+1], rx_q[4*w+2], rx_q[4*w+3]});
        rx_q.delete();
        blk_busy = 1'b1;
        done     = 1'b1;
      end
    end
    tick();
    bus.RX_DV_in = 1'b0;
    if (done) check("latency_valid", bus.MP_valid_out, 1);
  endtask

  task automatic send_block(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      send_byte(blk[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while ((blk_busy || exp_q.size() != 0) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check({tag, "_drained"}, (cyc < 3000), 1);
    check({tag, "_busy_idle"}, bus.MP_busy_out, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_word"}, bus.MP_word_out, 0);
    check({tag, "_rst_valid"}, bus.MP_valid_out, 0);
    check({tag, "_rst_last"}, bus.MP_last_out, 0);
    check({tag, "_rst_idx"}, bus.MP_word_idx_out, 0);
    check({tag, "_rst_busy"}, bus.MP_busy_out, 0);
    check({tag, "_rst_overrun"}, bus.MP_overrun_out, 0);
    check({tag, "_rst_timeout"}, bus.MP_timeout_out, 0);
    rx_q.delete();
    exp_q.delete();
    blk_busy = 1'b0;
    drain    = 1'b0;
    exp_ovr  = 1'b0;
    exp_idx  = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    int p0;
    logic [31:0] held;
    int cyc;

    rst_n = 1'b1;
    bus.RX_byte_in    = 8'h00;
    bus.RX_DV_in      = 1'b0;
    bus.core_ready_in = 1'b0;
    #2;
    do_reset("por");

    // "abc" padded block with the core always ready.
    bus.core_ready_in = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[0] = 8'h61; blk[1] = 8'h62; blk[2] = 8'h63; blk[3] = 8'h80; blk[63] = 8'h18;
    x0 = n_xfer;
    send_byte(blk[0]);
    check("collect_busy", bus.MP_busy_out, 1);
    send_block(1, 63, 0);
    wait_drain("abc");
    check("abc_xfers", n_xfer - x0, 16);

    // Backpressure: stall five cycles while word 3 is presented.
    fill_random();
    x0 = n_xfer;
    send_block(0, 63, 1);
    cyc = 0;
    while (!(bus.MP_valid_out === 1'b1 && bus.MP_word_idx_out == 4'd3) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("bp_reach_idx3", (cyc < 100), 1);
    bus.core_ready_in = 1'b0;
    held = exp_q[0];
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", bus.MP_valid_out, 1);
      check("bp_idx", bus.MP_word_idx_out, 3);
      check("bp_word", bus.MP_word_out, held);
      tick();
    end
    bus.core_ready_in = 1'b1;
    wait_drain("bp");
    check("bp_xfers", n_xfer - x0, 16);

    // Overrun: two strobes while the block is held in SEND.
    bus.core_ready_in = 1'b0;
    fill_random();
    send_block(0, 63, 2);
    send_byte(8'hA5);
    send_byte(8'h5A);
    check("ovr_set", bus.MP_overrun_out, 1);
    rand_ready = 1'b1;
    wait_drain("ovr");
    check("ovr_sticky", bus.MP_overrun_out, exp_ovr);
    rand_ready = 1'b0;
    bus.core_ready_in = 1'b1;

    // Back-to-back: next block's first byte lands one cycle after CLEANUP and clears overrun.
    fill_random();
    send_byte(blk[0]);
    check("ovr_clear", bus.MP_overrun_out, exp_ovr);
    send_block(1, 63, 0);
    wait_drain("b2b_1");
    fill_random();
    x0 = n_xfer;
    send_block(0, 63, 0);
    wait_drain("b2b_2");
    check("b2b_xfers", n_xfer - x0, 16);

    // Reset after byte 40 discards the partial block.
    fill_random();
    send_block(0, 39, 1);
    do_reset("mid");
    for (int i = 0; i < 64; i++) blk[i] = 8'(i);
    send_block(0, 63, 0);
    wait_drain("post_rst");

    // Randomised blocks with random ready and random byte gaps.
    rand_ready = 1'b1;
    repeat (3) begin
      fill_random();
      x0 = n_xfer;
      send_block(0, 63, 3);
      wait_drain("rand");
      check("rand_xfers", n_xfer - x0, 16);
    end
    rand_ready = 1'b0;
    bus.core_ready_in = 1'b1;

    // Idle gap inside a block.
    fill_random();
    p0 = n_pulse;
    send_block(0, 9, 0);
`ifdef MP_IN_TIMEOUT_EN
    repeat (99) tick();
    check("to_early", n_pulse - p0, 0);
    repeat (50) tick();
    check("to_pulses", n_pulse - p0, 1);
    check("to_idle", bus.MP_busy_out, 0);
    rx_q.delete();
    fill_random();
    send_block(0, 63, 1);
    wait_drain("after_to");
`else
    repeat (120) tick();
    check("no_to_pulse", n_pulse - p0, 0);
    check("no_to_busy", bus.MP_busy_out, 1);
    send_block(10, 63, 1);
    wait_drain("no_to");
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
